// File: rtl/axi_llc_pkg.sv
// Shared LLC types: cache-unit encodings, data-way request payload
// and arbitration defaults.
package axi_llc_pkg;

    typedef enum logic [1:0] {
        EvictUnit = 2'd0,
        RefilUnit = 2'd1,
        WChanUnit = 2'd2,
        RChanUnit = 2'd3
    } cache_unit_e;

    localparam int unsigned NumCacheUnits = 4;
    localparam int unsigned DefMaxStarve  = 8;

    typedef struct packed {
        logic [1:0]  cache_unit;
        logic [7:0]  way_ind;
        logic [15:0] line_addr;
        logic [1:0]  blk_offset;
        logic        we;
        logic [63:0] data;
        logic [7:0]  strb;
    } llc_way_inp_t;

endpackage

// File: rtl/axi_llc_rr_pick.sv
// Combinational round-robin pick: first valid input at or after ptr_i,
// wrapping; returns a one-hot grant and the matching index.
module axi_llc_rr_pick #(
    parameter  int unsigned NumIn = 4,
    localparam int unsigned IdxW  = $clog2(NumIn)
) (
    input  logic [NumIn-1:0] valid_i,
    input  logic [IdxW-1:0]  ptr_i,
    output logic [NumIn-1:0] gnt_o,
    output logic [IdxW-1:0]  idx_o,
    output logic             any_o
);

    int unsigned       pos;
    logic [IdxW-1:0]   pos_idx;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        pos     = 0;
        pos_idx = '0;
        for (int unsigned k = 0; k < NumIn; k++) begin
            pos     = (32'(ptr_i) + k) % NumIn;
            pos_idx = pos[IdxW-1:0];
            if (!any_o && valid_i[pos_idx]) begin
                any_o          = 1'b1;
                gnt_o[pos_idx] = 1'b1;
                idx_o          = pos_idx;
            end
        end
    end

endmodule

// File: rtl/axi_llc_data_way_arbiter.sv
// Data-way port arbiter: round-robin with starvation boost into a one-entry
// output register. Define AXI_LLC_WAY_ARB_PERF_EN for per-unit grant counters.
module axi_llc_data_way_arbiter
    import axi_llc_pkg::*;
#(
    parameter  int unsigned NumUnits  = NumCacheUnits,
    parameter  int unsigned MaxStarve = DefMaxStarve,
    parameter  type         way_inp_t = llc_way_inp_t,
    localparam int unsigned IdxWidth  = $clog2(NumUnits)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  way_inp_t            req_i [NumUnits],
    input  logic [NumUnits-1:0] req_valid_i,
    output logic [NumUnits-1:0] req_ready_o,
    output way_inp_t            way_inp_o,
    output logic                way_inp_valid_o,
    input  logic                way_inp_ready_i,
    output logic [IdxWidth-1:0] unit_idx_o,
    output logic [NumUnits-1:0] starve_o
`ifdef AXI_LLC_WAY_ARB_PERF_EN
    ,
    output logic [31:0]         grant_cnt_o [NumUnits]
`endif
);

    localparam int unsigned         CntWidth = $clog2(MaxStarve + 1);
    localparam logic [CntWidth-1:0] CntMax   = CntWidth'(MaxStarve);
    localparam logic [IdxWidth-1:0] LastIdx  = IdxWidth'(NumUnits - 1);

    logic                load;
    logic [NumUnits-1:0] starve;
    logic [NumUnits-1:0] boost_valid;
    logic [NumUnits-1:0] rr_gnt, bst_gnt, gnt;
    logic [IdxWidth-1:0] rr_idx, bst_idx, win_idx;
    logic                rr_any, bst_any, win_any;

    logic                valid_d, valid_q;
    way_inp_t            way_inp_d, way_inp_q;
    logic [IdxWidth-1:0] idx_d, idx_q;
    logic [IdxWidth-1:0] ptr_d, ptr_q;
    logic [CntWidth-1:0] starve_cnt_d [NumUnits];
    logic [CntWidth-1:0] starve_cnt_q [NumUnits];

    assign load = !valid_q || way_inp_ready_i;

    always_comb begin
        starve = '0;
        for (int u = 0; u < NumUnits; u++) begin
            starve[u] = starve_cnt_q[u] >= CntMax;
        end
    end

    assign boost_valid = req_valid_i & starve;

    axi_llc_rr_pick #(
        .NumIn (NumUnits)
    ) i_rr_pick (
        .valid_i (req_valid_i),
        .ptr_i   (ptr_q),
        .gnt_o   (rr_gnt),
        .idx_o   (rr_idx),
        .any_o   (rr_any)
    );

    // Boosted units are served lowest-index first, independent of the pointer.
    axi_llc_rr_pick #(
        .NumIn (NumUnits)
    ) i_boost_pick (
        .valid_i (boost_valid),
        .ptr_i   ('0),
        .gnt_o   (bst_gnt),
        .idx_o   (bst_idx),
        .any_o   (bst_any)
    );

    always_comb begin
        gnt     = '0;
        win_idx = rr_idx;
        win_any = load && rr_any;
        if (bst_any) begin
            win_idx = bst_idx;
        end
        if (load) begin
            gnt = bst_any ? bst_gnt : rr_gnt;
        end
    end

    assign req_ready_o = gnt;

    always_comb begin
        valid_d   = valid_q;
        way_inp_d = way_inp_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        if (load) begin
            valid_d = win_any;
            if (win_any) begin
                way_inp_d = req_i[win_idx];
                idx_d     = win_idx;
                ptr_d     = (win_idx == LastIdx) ? '0
                                                 : win_idx + IdxWidth'(1);
            end
        end
    end

    always_comb begin
        for (int u = 0; u < NumUnits; u++) begin
            starve_cnt_d[u] = starve_cnt_q[u];
            if (!req_valid_i[u] || gnt[u]) begin
                starve_cnt_d[u] = '0;
            end else if (starve_cnt_q[u] != CntMax) begin
                starve_cnt_d[u] = starve_cnt_q[u] + CntWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q   <= 1'b0;
            way_inp_q <= '0;
            idx_q     <= '0;
            ptr_q     <= '0;
            for (int u = 0; u < NumUnits; u++) begin
                starve_cnt_q[u] <= '0;
            end
        end else begin
            valid_q   <= valid_d;
            way_inp_q <= way_inp_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            for (int u = 0; u < NumUnits; u++) begin
                starve_cnt_q[u] <= starve_cnt_d[u];
            end
        end
    end

    assign way_inp_o       = way_inp_q;
    assign way_inp_valid_o = valid_q;
    assign unit_idx_o      = idx_q;
    assign starve_o        = starve;

`ifdef AXI_LLC_WAY_ARB_PERF_EN
    logic [31:0] grant_cnt_d [NumUnits];
    logic [31:0] grant_cnt_q [NumUnits];

    always_comb begin
        for (int u = 0; u < NumUnits; u++) begin
            grant_cnt_d[u] = grant_cnt_q[u] + 32'(gnt[u]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int u = 0; u < NumUnits; u++) begin
                grant_cnt_q[u] <= '0;
            end
        end else begin
            for (int u = 0; u < NumUnits; u++) begin
                grant_cnt_q[u] <= grant_cnt_d[u];
            end
        end
    end

    assign grant_cnt_o = grant_cnt_q;
`endif

endmodule

// File: tb/tb_axi_llc_data_way_arbiter.sv
// Directed bench for the data-way arbiter with a cycle-level reference model.
module tb_axi_llc_data_way_arbiter;
    import axi_llc_pkg::*;

    localparam int N  = 4;
    localparam int MS = 4;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    llc_way_inp_t req_i [N];
    logic [N-1:0] req_valid_i;
    logic [N-1:0] req_ready_o;
    llc_way_inp_t way_inp_o;
    logic         way_inp_valid_o;
    logic         way_inp_ready_i;
    logic [1:0]   unit_idx_o;
    logic [N-1:0] starve_o;
`ifdef AXI_LLC_WAY_ARB_PERF_EN
    logic [31:0]  grant_cnt_o [N];
`endif

    axi_llc_data_way_arbiter #(
        .NumUnits  (N),
        .MaxStarve (MS)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .req_i           (req_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .way_inp_o       (way_inp_o),
        .way_inp_valid_o (way_inp_valid_o),
        .way_inp_ready_i (way_inp_ready_i),
        .unit_idx_o      (unit_idx_o),
        .starve_o        (starve_o)
`ifdef AXI_LLC_WAY_ARB_PERF_EN
        ,
        .grant_cnt_o     (grant_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;
    int cyc_cnt  = 0;

    llc_way_inp_t q [N][$];
    int           log_idx [$];
    logic [63:0]  log_dat [$];
    int           log_cyc [$];
    int           exp_q [$];

    // reference model state
    bit           m_valid;
    llc_way_inp_t m_pay;
    int           m_idx;
    int           m_ptr;
    int           m_cnt [N];
    int           m_gcnt [N];

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     nm, act, exp, cyc_cnt);
        end
    endtask

    function automatic llc_way_inp_t mk(int u, int n);
        llc_way_inp_t p;
        p            = '0;
        p.cache_unit = 2'(u);
        p.way_ind    = 8'(1 << u);
        p.line_addr  = 16'(n * 16 + u);
        p.blk_offset = 2'(n);
        p.we         = 1'(n);
        p.data       = {32'(u + 1), 32'(n + 100)};
        p.strb       = 8'(n * 3 + 1);
        return p;
    endfunction

    function automatic int pick();
        if (m_valid && !way_inp_ready_i) return -1;
        for (int u = 0; u < N; u++)
            if (req_valid_i[u] && m_cnt[u] >= MS) return u;
        for (int k = 0; k < N; k++)
            if (req_valid_i[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 0;
        m_pay   = '0;
        m_idx   = 0;
        m_ptr   = 0;
        for (int u = 0; u < N; u++) begin
            m_cnt[u]  = 0;
            m_gcnt[u] = 0;
        end
    endtask

    always @(negedge rst_ni) model_reset();

    always @(posedge clk_i) cyc_cnt++;

    // Compare, log, retire handshakes, then advance the model to the next edge.
    always @(negedge clk_i) begin
        int w;
        logic [N-1:0] er, es;
        bit ld;
        if (rst_ni) begin
            w  = pick();
            er = '0;
            es = '0;
            if (w >= 0) er[w] = 1'b1;
            for (int u = 0; u < N; u++) es[u] = (m_cnt[u] >= MS);
            chk("req_ready", 128'(req_ready_o), 128'(er));
            chk("out_valid", 128'(way_inp_valid_o), 128'(m_valid));
            chk("starve", 128'(starve_o), 128'(es));
            if (m_valid) begin
                chk("unit_idx", 128'(unit_idx_o), 128'(m_idx));
                chk("payload", 128'(way_inp_o), 128'(m_pay));
            end
`ifdef AXI_LLC_WAY_ARB_PERF_EN
            for (int u = 0; u < N; u++)
                chk("grant_cnt", 128'(grant_cnt_o[u]), 128'(m_gcnt[u]));
`endif
            if (way_inp_valid_o && way_inp_ready_i) begin
                log_idx.push_back(int'(unit_idx_o));
                log_dat.push_back(way_inp_o.data);
                log_cyc.push_back(cyc_cnt);
            end
            for (int u = 0; u < N; u++)
                if (req_valid_i[u] && req_ready_o[u] && q[u].size() > 0)
                    void'(q[u].pop_front());
            ld = !m_valid || way_inp_ready_i;
            for (int u = 0; u < N; u++) begin
                if (!req_valid_i[u] || u == w) m_cnt[u] = 0;
                else if (m_cnt[u] < MS) m_cnt[u]++;
            end
            if (ld) begin
                if (w >= 0) begin
                    m_valid = 1;
                    m_pay   = req_i[w];
                    m_idx   = w;
                    m_ptr   = (w + 1) % N;
                    m_gcnt[w]++;
                end else begin
                    m_valid = 0;
                end
            end
        end
    end

    // Request driver: present each unit's queue head just after the edge.
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            for (int u = 0; u < N; u++) begin
                req_valid_i[u] = q[u].size() > 0;
                if (q[u].size() > 0) req_i[u] = q[u][0];
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge clk_i);
            #2;
        end
    endtask

    task automatic drain(int lim);
        int  n;
        bit  busy;
        n    = 0;
        busy = 1;
        while (busy && n < lim) begin
            cyc(1);
            n++;
            busy = way_inp_valid_o || (req_valid_i != '0);
            for (int u = 0; u < N; u++) if (q[u].size() > 0) busy = 1;
        end
        chk("drain_timeout", 128'(busy), 128'(0));
    endtask

    task automatic expect_log(string nm);
        chk({nm, "_len"}, 128'(log_idx.size()), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_idx.size(); i++)
            chk({nm, "_idx"}, 128'(log_idx[i]), 128'(exp_q[i]));
    endtask

    task automatic clear_log();
        log_idx.delete();
        log_dat.delete();
        log_cyc.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni          = 1'b0;
        way_inp_ready_i = 1'b0;
        req_valid_i     = '0;
        for (int u = 0; u < N; u++) req_i[u] = '0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_valid", 128'(way_inp_valid_o), 128'(0));
        chk("rst_idx", 128'(unit_idx_o), 128'(0));
        chk("rst_payload", 128'(way_inp_o), 128'(0));
        chk("rst_starve", 128'(starve_o), 128'(0));
        @(posedge clk_i);
        #2;
        rst_ni = 1'b1;

        // rotation: all units valid, downstream always ready
        way_inp_ready_i = 1'b1;
        for (int n = 0; n < 2; n++)
            for (int u = 0; u < N; u++) q[u].push_back(mk(u, n));
        drain(40);
        exp_q = {0, 1, 2, 3, 0, 1, 2, 3};
        expect_log("rotation");
        if (log_cyc.size() == 8)
            chk("rotation_bubble", 128'(log_cyc[7] - log_cyc[0]), 128'(7));
        clear_log();

        // single requester, three back-to-back requests
        for (int n = 0; n < 3; n++) q[2].push_back(mk(2, n));
        drain(20);
        exp_q = {2, 2, 2};
        expect_log("single");
        for (int i = 0; i < 3 && i < log_dat.size(); i++)
            chk("single_data", 128'(log_dat[i]), {96'd0, 32'd100 + 32'(i)} | 128'(64'h3_0000_0000));
        if (log_cyc.size() == 3)
            chk("single_bubble", 128'(log_cyc[2] - log_cyc[0]), 128'(2));
        clear_log();

        // backpressure: unit 1 held while unit 0 waits
        way_inp_ready_i = 1'b0;
        q[1].push_back(mk(1, 5));
        cyc(2);
        q[0].push_back(mk(0, 5));
        cyc(5);
        chk("bp_valid", 128'(way_inp_valid_o), 128'(1));
        chk("bp_idx", 128'(unit_idx_o), 128'(1));
        chk("bp_ready", 128'(req_ready_o), 128'(0));
        chk("bp_payload", 128'(way_inp_o), 128'(mk(1, 5)));
        way_inp_ready_i = 1'b1;
        drain(20);
        exp_q = {1, 0};
        expect_log("backpressure");
        if (log_cyc.size() == 2)
            chk("bp_next", 128'(log_cyc[1] - log_cyc[0]), 128'(1));
        clear_log();

        // starvation: units 0 and 3 boosted behind a stalled output
        way_inp_ready_i = 1'b0;
        q[2].push_back(mk(2, 7));
        cyc(2);
        q[0].push_back(mk(0, 7));
        q[3].push_back(mk(3, 7));
        cyc(MS + 2);
        chk("starve_set", 128'(starve_o), 128'(4'b1001));
        way_inp_ready_i = 1'b1;
        drain(20);
        exp_q = {2, 0, 3};
        expect_log("starvation");
        chk("starve_clear", 128'(starve_o), 128'(0));
        clear_log();

        // reset while a request is pending at the output
        way_inp_ready_i = 1'b0;
        q[1].push_back(mk(1, 9));
        cyc(2);
        chk("pre_rst_valid", 128'(way_inp_valid_o), 128'(1));
        for (int u = 0; u < N; u++) q[u].delete();
        req_valid_i = '0;
        rst_ni      = 1'b0;
        #1;
        chk("mid_rst_valid", 128'(way_inp_valid_o), 128'(0));
        chk("mid_rst_idx", 128'(unit_idx_o), 128'(0));
        chk("mid_rst_payload", 128'(way_inp_o), 128'(0));
        chk("mid_rst_starve", 128'(starve_o), 128'(0));
        cyc(1);
        rst_ni = 1'b1;
        clear_log();
        way_inp_ready_i = 1'b1;
        q[0].push_back(mk(0, 11));
        q[3].push_back(mk(3, 11));
        drain(20);
        exp_q = {0, 3};
        expect_log("post_rst");
        clear_log();

        // ten grants to unit 3
        for (int n = 0; n < 10; n++) q[3].push_back(mk(3, n));
        drain(40);
        chk("u3_burst_len", 128'(log_idx.size()), 128'(10));
`ifdef AXI_LLC_WAY_ARB_PERF_EN
        chk("perf_u0", 128'(grant_cnt_o[0]), 128'(1));
        chk("perf_u1", 128'(grant_cnt_o[1]), 128'(0));
        chk("perf_u2", 128'(grant_cnt_o[2]), 128'(0));
        chk("perf_u3", 128'(grant_cnt_o[3]), 128'(11));
`endif
        clear_log();

        cyc(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
